// File: rtl/spi_master_tx.sv
// Mode-0 SPI master: one byte per chip-select frame, MSB first.
// Captures miso full-duplex and strobes the received byte on rx_val.
module spi_master_tx #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       val,
    output logic       rdy,
    output logic       cs,
    output logic       sclk,
    output logic       mosi,
    input  logic       miso,
    output logic [7:0] rx_data,
    output logic       rx_val
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] PH_MAX = 8'(DIV - 1);

    state_t     state, state_n;
    logic [7:0] phase, phase_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] tx_sr, tx_n;
    logic [7:0] rx_sr, rx_n;
    logic       cs_n, sclk_n, mosi_n, rdy_n;
    logic [7:0] rx_data_n;
    logic       rx_val_n;
    logic       miso_s1, miso_s2;
    logic       ph_last;

    assign ph_last = (phase == PH_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            phase   <= 8'd0;
            bit_cnt <= 3'd0;
            tx_sr   <= 8'd0;
            rx_sr   <= 8'd0;
            cs      <= 1'b1;
            sclk    <= 1'b0;
            mosi    <= 1'b0;
            rdy     <= 1'b0;
            rx_data <= 8'd0;
            rx_val  <= 1'b0;
            miso_s1 <= 1'b0;
            miso_s2 <= 1'b0;
        end else begin
            state   <= state_n;
            phase   <= phase_n;
            bit_cnt <= bit_n;
            tx_sr   <= tx_n;
            rx_sr   <= rx_n;
            cs      <= cs_n;
            sclk    <= sclk_n;
            mosi    <= mosi_n;
            rdy     <= rdy_n;
            rx_data <= rx_data_n;
            rx_val  <= rx_val_n;
            miso_s1 <= miso;
            miso_s2 <= miso_s1;
        end
    end

    always_comb begin
        state_n   = state;
        phase_n   = phase + 8'd1;
        bit_n     = bit_cnt;
        tx_n      = tx_sr;
        rx_n      = rx_sr;
        cs_n      = cs;
        sclk_n    = sclk;
        mosi_n    = mosi;
        rdy_n     = rdy;
        rx_data_n = rx_data;
        rx_val_n  = 1'b0;
        unique case (state)
            IDLE: begin
                phase_n = 8'd0;
                rdy_n   = 1'b1;
                if (val && rdy) begin
                    state_n = SETUP;
                    tx_n    = {data_in[6:0], 1'b0};
                    bit_n   = 3'd0;
                    cs_n    = 1'b0;
                    mosi_n  = data_in[7];
                    rdy_n   = 1'b0;
                end
            end
            SETUP: begin
                if (ph_last) begin
                    state_n = HIGH;
                    phase_n = 8'd0;
                    sclk_n  = 1'b1;
                end
            end
            HIGH: begin
                if (ph_last) begin
                    rx_n    = {rx_sr[6:0], miso_s2};
                    sclk_n  = 1'b0;
                    phase_n = 8'd0;
                    if (bit_cnt == 3'd7) begin
                        state_n = HOLD;
                    end else begin
                        // next bit leaves on the falling edge
                        state_n = LOW;
                        bit_n   = bit_cnt + 3'd1;
                        mosi_n  = tx_sr[7];
                        tx_n    = {tx_sr[6:0], 1'b0};
                    end
                end
            end
            LOW: begin
                if (ph_last) begin
                    state_n = HIGH;
                    phase_n = 8'd0;
                    sclk_n  = 1'b1;
                end
            end
            HOLD: begin
                if (ph_last) begin
                    state_n   = GAP;
                    phase_n   = 8'd0;
                    cs_n      = 1'b1;
                    mosi_n    = 1'b0;
                    rx_data_n = rx_sr;
                    rx_val_n  = 1'b1;
                end
            end
            GAP: begin
                if (ph_last) begin
                    state_n = IDLE;
                    phase_n = 8'd0;
                    rdy_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Self-checking bench for spi_master_tx: table vectors, random bytes
// against a mode-0 slave/receiver model, loopback and corner sequences.
module tb_spi_master_tx;

    typedef struct {
        logic [7:0] d;
        logic [7:0] m;
        logic [7:0] exp_rx;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data_in = 8'd0;
    logic       val = 1'b0;
    logic       rdy, cs, sclk, mosi;
    logic       miso = 1'b0;
    logic [7:0] rx_data;
    logic       rx_val;

    logic [7:0] data3 = 8'd0;
    logic       val3 = 1'b0;
    logic       rdy3, cs3, sclk3, mosi3, miso3;
    logic [7:0] rx_data3;
    logic       rx_val3;

    int pass_cnt = 0;
    int total = 0;
    int cyc = 0;

    logic       rises[$];
    int         cs_low, rxv_cnt, rxv_cyc, rxv3_cnt;
    int         cs_hi_run, last_gap;
    logic [7:0] slave_byte = 8'd0;
    logic [7:0] slave_sh = 8'd0;
    logic [7:0] rcv_sr = 8'd0;
    logic [7:0] rcv_q[$];
    logic       cs_q = 1'b1;
    logic       sclk_q = 1'b0;

    vec_t tbl[5];

    spi_master_tx #(.DIV(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .val(val), .rdy(rdy),
        .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .rx_data(rx_data), .rx_val(rx_val)
    );

    spi_master_tx #(.DIV(3)) dut3 (
        .clk(clk), .rst(rst), .data_in(data3), .val(val3), .rdy(rdy3),
        .cs(cs3), .sclk(sclk3), .mosi(mosi3), .miso(miso3),
        .rx_data(rx_data3), .rx_val(rx_val3)
    );

    assign miso3 = mosi3;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, companion receiver and mode-0 slave, all on stable outputs
    always @(negedge clk) begin
        if (sclk && !sclk_q) begin
            rises.push_back(mosi);
            if (!cs) rcv_sr = {rcv_sr[6:0], mosi};
        end
        if (!cs) cs_low++;
        if (rx_val) begin
            rxv_cnt++;
            rxv_cyc = cyc;
        end
        if (rx_val3) rxv3_cnt++;
        if (cs) cs_hi_run++;
        else begin
            if (cs_hi_run > 0) last_gap = cs_hi_run;
            cs_hi_run = 0;
        end
        if (cs && !cs_q) rcv_q.push_back(rcv_sr);
        if (cs_q && !cs) begin
            miso = slave_byte[7];
            slave_sh = {slave_byte[6:0], 1'b0};
        end else if (!cs && sclk_q && !sclk) begin
            miso = slave_sh[7];
            slave_sh = {slave_sh[6:0], 1'b0};
        end
        cs_q = cs;
        sclk_q = sclk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic wait_rdy(input int lim);
        int n = 0;
        while (!rdy && n < lim) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic frame4(input logic [7:0] d, input logic [7:0] m,
                          input bit noisy, input string tag);
        int t0;
        int n;
        logic [7:0] got;
        wait_rdy(400);
        chk({tag, " rdy_pre"}, 32'(rdy), 32'd1);
        slave_byte = m;
        rises.delete();
        cs_low = 0;
        rxv_cnt = 0;
        rxv_cyc = 0;
        data_in = d;
        val = 1'b1;
        @(negedge clk);
        t0 = cyc;
        val = 1'b0;
        data_in = ~d;
        n = 0;
        while (!rdy && n < 400) begin
            if (noisy) begin
                val = 1'($urandom);
                data_in = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        val = 1'b0;
        got = 8'd0;
        for (int i = 0; i < rises.size() && i < 8; i++) got[7-i] = rises[i];
        chk({tag, " rises"}, 32'(rises.size()), 32'd8);
        chk({tag, " mosi_bits"}, 32'(got), 32'(d));
        chk({tag, " cs_low"}, 32'(cs_low), 32'd68);
        chk({tag, " rx_val_cnt"}, 32'(rxv_cnt), 32'd1);
        chk({tag, " rx_val_time"}, 32'(rxv_cyc - t0), 32'd68);
        chk({tag, " rx_data"}, 32'(rx_data), 32'(m));
        chk({tag, " rdy_time"}, 32'(cyc - t0), 32'd72);
    endtask

    task automatic frame3(input logic [7:0] d);
        int n = 0;
        while (!rdy3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        rxv3_cnt = 0;
        data3 = d;
        val3 = 1'b1;
        @(negedge clk);
        val3 = 1'b0;
        n = 0;
        while (!rdy3 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("loop rx_data", 32'(rx_data3), 32'(d));
        chk("loop rx_val_cnt", 32'(rxv3_cnt), 32'd1);
    endtask

    initial begin
        logic [7:0] rd, rm;
        tbl[0] = '{8'hA5, 8'hFF, 8'hFF};
        tbl[1] = '{8'h3C, 8'h00, 8'h00};
        tbl[2] = '{8'h81, 8'h5A, 8'h5A};
        tbl[3] = '{8'hFF, 8'h81, 8'h81};
        tbl[4] = '{8'h00, 8'hC3, 8'hC3};

        repeat (3) begin
            @(negedge clk);
            chk("rst cs", 32'(cs), 32'd1);
            chk("rst sclk", 32'(sclk), 32'd0);
            chk("rst mosi", 32'(mosi), 32'd0);
            chk("rst rx_val", 32'(rx_val), 32'd0);
            chk("rst rdy", 32'(rdy), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst rdy", 32'(rdy), 32'd1);
        chk("post_rst cs", 32'(cs), 32'd1);
        chk("post_rst rx_data", 32'(rx_data), 32'd0);

        frame3(8'h3C);
        frame3(8'h81);
        frame3(8'h00);

        for (int i = 0; i < 5; i++)
            frame4(tbl[i].d, tbl[i].m, 1'b0, $sformatf("vec%0d", i));
        for (int i = 0; i < 6; i++) begin
            rd = 8'($urandom);
            rm = 8'($urandom);
            frame4(rd, rm, 1'b0, $sformatf("rnd%0d", i));
        end

        wait_rdy(400);
        rcv_q.delete();
        data_in = 8'h12;
        val = 1'b1;
        @(negedge clk);
        data_in = 8'h34;
        wait_rdy(400);
        @(negedge clk);
        val = 1'b0;
        wait_rdy(400);
        chk("b2b count", 32'(rcv_q.size()), 32'd2);
        if (rcv_q.size() >= 2) begin
            chk("b2b byte0", 32'(rcv_q[0]), 32'h12);
            chk("b2b byte1", 32'(rcv_q[1]), 32'h34);
        end
        chk("b2b cs_gap", 32'(last_gap), 32'd5);

        frame4(8'hC6, 8'h6B, 1'b1, "noisy");
        repeat (8) @(negedge clk);
        chk("noisy no_extra cs", 32'(cs), 32'd1);
        chk("noisy no_extra rdy", 32'(rdy), 32'd1);

        wait_rdy(400);
        slave_byte = 8'h00;
        rises.delete();
        rxv_cnt = 0;
        data_in = 8'hC3;
        val = 1'b1;
        @(negedge clk);
        val = 1'b0;
        begin
            int n = 0;
            while (rises.size() < 4 && n < 400) begin
                @(negedge clk);
                n++;
            end
        end
        chk("midrst reached", 32'(rises.size()), 32'd4);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst cs", 32'(cs), 32'd1);
        chk("midrst sclk", 32'(sclk), 32'd0);
        chk("midrst mosi", 32'(mosi), 32'd0);
        chk("midrst rx_val", 32'(rx_val), 32'd0);
        chk("midrst rx_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst no_strobe", 32'(rxv_cnt), 32'd0);
        chk("midrst idle cs", 32'(cs), 32'd1);
        frame4(8'h5A, 8'($urandom), 1'b0, "after_rst");

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/spi_master_tx.md
# spi_master_tx

Mode-0 SPI master that turns a valid/ready byte stream into SPI frames on `cs`/`sclk`/`mosi`. It drives the byte-wide SPI receiver elsewhere in the design, or any external mode-0 slave. One byte is sent per chip-select frame, MSB first. The block also captures `miso` full-duplex and returns the received byte with a one-cycle strobe.

## Interface
- `DIV`, default 4: `sclk` half-period in `clk` cycles. Legal range is 3..255; 3 is the minimum because `miso` passes through a 2-flop synchronizer.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `data_in`  in  8  byte to transmit; sampled when `val & rdy`.
- `val`  in  1  `data_in` valid.
- `rdy`  out  1  block idle and can accept a byte.
- `cs`  out  1  chip select, active-low.
- `sclk`  out  1  SPI clock; idles low (CPOL=0).
- `mosi`  out  1  serial data out, MSB first.
- `miso`  in  1  serial data in; asynchronous to `clk`.
- `rx_data`  out  8  last byte received on `miso`.
- `rx_val`  out  1  one-cycle strobe; `rx_data` has just been updated.

## Operation
- All outputs are registered.
- Reset values: `cs`=1, `sclk`=0, `mosi`=0, `rdy`=0, `rx_data`=0, `rx_val`=0, state IDLE.
- `rdy` is 1 in IDLE whenever `rst`=0. The first accept is possible on the cycle after reset is released.
- State machine:
  - IDLE: on `val & rdy`, latch `data_in` into the TX shift register, clear the bit counter, and go to SETUP. On that same edge, `cs`→0, `mosi`→`data_in[7]`, `rdy`→0.
  - SETUP: `cs` low, `sclk` low, for DIV cycles; then go to HIGH and drive `sclk`→1.
  - HIGH: `sclk` high for DIV cycles. On the last cycle of HIGH, shift the synchronized `miso` into the RX shift register (LSB in). Then drive `sclk`→0.
    - If bit counter = 7, go to HOLD.
    - Otherwise go to LOW: increment the bit counter and drive `mosi`→next TX bit on the same edge that `sclk` falls.
  - LOW: `sclk` low for DIV cycles; then go to HIGH.
  - HOLD: `sclk` low, `cs` low, for DIV cycles. On exit: `cs`→1, `mosi`→0, `rx_data`←RX shift register, `rx_val`→1 for one cycle. Go to GAP.
  - GAP: `cs` high for DIV cycles; then go to IDLE with `rdy`→1.
- `mosi` changes only when `sclk` falls or `cs` falls, so it is stable around every rising edge (mode 0).
- `miso` uses a 2-flop synchronizer. The sample point is DIV-1 cycles after the rising edge, which covers the synchronizer delay when DIV≥3.
- Bit counter is 3 bits and does not wrap past 7 within a frame. Phase counter is 8 bits, counts 0..DIV-1, and reloads on every state change.
- `val` is ignored outside IDLE. `data_in` changes after an accept have no effect on the frame in flight.
- There is no backpressure on `rx_val`. A consumer that misses the strobe still reads `rx_data`, which stays stable until the next frame completes.
- Reset mid-frame: on the next edge `cs`→1, `sclk`→0, `mosi`→0, `rx_val`=0 (no strobe is ever issued for an aborted frame), `rx_data` cleared, state IDLE.

## Timing
- Accept edge is T.
  - `cs` low from T through T+17·DIV-1: exactly 17·DIV cycles.
  - First `sclk` rise at T+DIV. Rise k (k=0..7) at T+DIV+2k·DIV. Each high phase is DIV cycles; each full bit period is 2·DIV cycles.
  - `rx_val` pulse and `cs` rise both occur at T+17·DIV.
  - `rdy` returns to 1 at T+18·DIV.
- Throughput is one byte per 18·DIV cycles.
- Back-to-back: if `val` is held high, the next accept occurs on the first IDLE cycle. `cs` is high for exactly DIV+1 cycles between frames.
- For the companion receiver (3-cycle synchronizer plus edge detect), DIV≥3 guarantees every rising edge and `cs` transition is detected.

## Test plan
- Reset behaviour: assert `rst` for 3 cycles, then release. Require `cs`=1, `sclk`=0, `mosi`=0, `rx_val`=0 during and after reset, and `rdy`=1 on the cycle after release.
- Single byte, DIV=4: send 0xA5 with `miso` tied 1. Require exactly 8 `sclk` rises. The `mosi` values at the rises must read 1,0,1,0,0,1,0,1. Require `cs` low for 68 cycles, `rx_data`=0xFF with a single `rx_val` pulse, and `rdy` back at T+72.
- Loopback, DIV=3: tie `miso`=`mosi`, then send 0x3C, 0x81, 0x00. Require `rx_data` equal to each byte in turn, with each capture marked by exactly one `rx_val` pulse.
- Back-to-back with the companion receiver, DIV=4: hold `val`=1 and send 0x12, 0x34. Require the receiver to report 0x12 then 0x34, and require `cs` high for exactly 5 cycles between frames.
- Mid-frame reset: assert `rst` during the 4th HIGH phase. Require `cs`=1 and `sclk`=0 on the next edge, no `rx_val`, `rx_data`=0. A subsequent 0x5A frame must complete normally.
- Ignored input: toggle `val` and change `data_in` while a frame is in flight. Require `mosi` to follow the originally accepted byte and no extra frame to be started.
